// File: rtl/vx_gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vx_gpu_pkg
// Description : Shared types and helpers for the commit path: the commit
//               packet layout, its width, and the retire-count width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vx_gpu_pkg;

    // Default slice configuration
    localparam int c_num_lanes = 4;
    localparam int c_nw_bits   = 2;
    localparam int c_nr_bits   = 6;
    localparam int c_xlen      = 32;
    localparam int c_uuid_bits = 44;

    // Packet width for an arbitrary configuration
    function automatic int calc_pktw(input int uuid_bits, input int nw_bits,
                                     input int num_lanes, input int xlen,
                                     input int nr_bits);
        return uuid_bits + nw_bits + num_lanes + xlen + 1 + nr_bits
               + num_lanes * xlen + 2;
    endfunction

    // Bits needed to hold a popcount of n lanes (0..n)
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int c_pktw = calc_pktw(c_uuid_bits, c_nw_bits, c_num_lanes,
                                      c_xlen, c_nr_bits);

    // Commit packet, MSB first; eop is bit 0, sop bit 1
    typedef struct packed {
        logic [c_uuid_bits-1:0]          uuid;
        logic [c_nw_bits-1:0]            wid;
        logic [c_num_lanes-1:0]          tmask;
        logic [c_xlen-1:0]               pc;
        logic                            wb;
        logic [c_nr_bits-1:0]            rd;
        logic [c_num_lanes*c_xlen-1:0]   data;
        logic                            sop;
        logic                            eop;
    } commit_pkt_t;

endpackage
`default_nettype wire

// File: rtl/vx_commit_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : vx_commit_skid_buf
// Description : Two-entry elastic buffer. Head entry is held stable until
//               popped; entries leave in arrival order.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_commit_skid_buf #(
    parameter int DATAW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push_valid,
    input  logic [DATAW-1:0] i_push_data,
    output logic             o_full,
    output logic             o_pop_valid,
    output logic [DATAW-1:0] o_pop_data,
    input  logic             i_pop_ready
);
    import vx_gpu_pkg::*;

    logic [DATAW-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full      = (r_count == 2'd2);
    assign o_pop_valid = (r_count != 2'd0);
    assign o_pop_data  = r_mem[r_rd_ptr];
    assign w_push      = i_push_valid && !o_full;
    assign w_pop       = o_pop_valid && i_pop_ready;

    // Occupancy and pointers; push+pop together leaves the count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/vx_commit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vx_commit_arbiter
// Description : Round-robin merge of per-unit commit streams into one
//               writeback stream, holding multi-packet responses together,
//               buffered by a 2-entry skid buffer, with retired-thread count.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_commit_arbiter
    import vx_gpu_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int NUM_LANES = 4,
    parameter int NW_BITS   = 2,
    parameter int NR_BITS   = 6,
    parameter int XLEN      = 32,
    parameter int UUID_BITS = 44,
    parameter int PKTW      = calc_pktw(UUID_BITS, NW_BITS, NUM_LANES, XLEN, NR_BITS),
    parameter int UNIT_W    = $clog2(NUM_UNITS),
    parameter int CNT_W     = cnt_width(NUM_LANES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_UNITS-1:0]      in_valid,
    input  logic [NUM_UNITS*PKTW-1:0] in_data,
    output logic [NUM_UNITS-1:0]      in_ready,
    output logic                      out_valid,
    output logic [PKTW-1:0]           out_data,
    output logic [UNIT_W-1:0]         out_unit,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          instret_inc,
    output logic [63:0]               instret
);

    // tmask sits above data, rd, wb and pc
    localparam int              c_tmask_lo = 2 + NUM_LANES * XLEN + NR_BITS + 1 + XLEN;
    localparam logic [UNIT_W:0] c_units    = (UNIT_W+1)'(NUM_UNITS);
    localparam logic [UNIT_W-1:0] c_last   = UNIT_W'(NUM_UNITS - 1);

    logic [UNIT_W-1:0]      r_rr_ptr;
    logic                   r_locked;
    logic [UNIT_W-1:0]      r_lock_unit;
    logic [CNT_W-1:0]       r_instret_inc;
    logic [63:0]            r_instret;

    logic                   w_found;
    logic [UNIT_W-1:0]      w_gnt;
    logic [UNIT_W:0]        w_sum;
    logic [UNIT_W-1:0]      w_gnt_next;
    logic                   w_buf_full;
    logic                   w_fire;
    logic [PKTW-1:0]        w_gnt_pkt;
    logic                   w_out_fire;
    logic [CNT_W-1:0]       w_pop_cnt;
    logic [UNIT_W+PKTW-1:0] w_buf_out;

    // Grant: the locked unit only, otherwise first valid unit from rr_ptr
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_sum   = '0;
        if (r_locked) begin
            w_found = in_valid[r_lock_unit];
            w_gnt   = r_lock_unit;
        end else begin
            // Scan farthest first so the nearest valid unit wins
            for (int k = NUM_UNITS - 1; k >= 0; k--) begin
                w_sum = {1'b0, r_rr_ptr} + (UNIT_W+1)'(k);
                if (w_sum >= c_units) w_sum = w_sum - c_units;
                if (in_valid[w_sum[UNIT_W-1:0]]) begin
                    w_found = 1'b1;
                    w_gnt   = w_sum[UNIT_W-1:0];
                end
            end
        end
    end

    assign w_fire     = w_found && !w_buf_full && !reset;
    assign w_gnt_pkt  = in_data[w_gnt*PKTW +: PKTW];
    assign w_gnt_next = (w_gnt == c_last) ? '0 : w_gnt + UNIT_W'(1);

    // One-hot ready toward the granted unit only
    always_comb begin
        in_ready = '0;
        if (w_fire) in_ready[w_gnt] = 1'b1;
    end

    // Lock holds a sop..eop response together; pointer advances on eop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_locked    <= 1'b0;
            r_lock_unit <= '0;
        end else if (w_fire) begin
            if (w_gnt_pkt[0]) begin
                r_locked <= 1'b0;
                r_rr_ptr <= w_gnt_next;
            end else if (w_gnt_pkt[1]) begin
                r_locked    <= 1'b1;
                r_lock_unit <= w_gnt;
            end
        end
    end

    vx_commit_skid_buf #(
        .DATAW (UNIT_W + PKTW)
    ) u_skid (
        .clk          (clk),
        .rst          (reset),
        .i_push_valid (w_fire),
        .i_push_data  ({w_gnt, w_gnt_pkt}),
        .o_full       (w_buf_full),
        .o_pop_valid  (out_valid),
        .o_pop_data   (w_buf_out),
        .i_pop_ready  (out_ready)
    );

    assign out_unit   = w_buf_out[PKTW +: UNIT_W];
    assign out_data   = w_buf_out[PKTW-1:0];
    assign w_out_fire = out_valid && out_ready;

    // Active lanes of the packet leaving toward writeback
    always_comb begin
        w_pop_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_pop_cnt = w_pop_cnt + CNT_W'(out_data[c_tmask_lo + i]);
        end
    end

    // Retired-thread pulse and running count, updated on eop writeback
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instret_inc <= '0;
            r_instret     <= '0;
        end else begin
            r_instret_inc <= (w_out_fire && out_data[0]) ? w_pop_cnt : '0;
            if (w_out_fire && out_data[0]) begin
                r_instret <= r_instret + 64'(w_pop_cnt);
            end
        end
    end

    assign instret_inc = r_instret_inc;
    assign instret     = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_vx_commit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vx_commit_arbiter
// Description : Self-checking bench for vx_commit_arbiter: directed scenarios
//               plus randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_commit_arbiter;
    import vx_gpu_pkg::*;

    localparam int N    = 4;
    localparam int PKTW = c_pktw;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      in_valid = '0;
    logic [N*PKTW-1:0] in_data  = '0;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [PKTW-1:0]   out_data;
    logic [1:0]        out_unit;
    logic              out_ready = 1'b0;
    logic [2:0]        instret_inc;
    logic [63:0]       instret;

    vx_commit_arbiter dut (
        .clk         (clk),
        .reset       (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_unit    (out_unit),
        .out_ready   (out_ready),
        .instret_inc (instret_inc),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    // Reference model: buffered packets in order, pointer, lock owner, counts
    typedef struct {
        int              unit;
        logic [PKTW-1:0] pkt;
    } ent_t;

    ent_t        m_q[$];
    int          m_rr;
    int          m_lock;
    logic [63:0] m_instret;
    int          m_inc;

    int n_chk = 0;
    int n_err = 0;
    int lock_viol = 0;
    int obs_acc = 0;
    int rem [N];
    int blen [N];

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [PKTW-1:0] mk_pkt(input logic [3:0] tm, input logic sop, input logic eop);
        commit_pkt_t p;
        logic [63:0] r64;
        logic [31:0] r32;
        r64     = {$urandom(), $urandom()};
        r32     = $urandom();
        p.uuid  = r64[43:0];
        p.wid   = r32[1:0];
        p.tmask = tm;
        p.pc    = $urandom();
        p.wb    = r32[2];
        p.rd    = r32[8:3];
        p.data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        p.sop   = sop;
        p.eop   = eop;
        return p;
    endfunction

    task automatic put(input int u, input logic [3:0] tm, input logic sop, input logic eop);
        in_data[u*PKTW +: PKTW] = mk_pkt(tm, sop, eop);
        in_valid[u] = 1'b1;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rr      = 0;
        m_lock    = -1;
        m_instret = '0;
        m_inc     = 0;
    endtask

    // One clock: check outputs at negedge against the model, advance model at posedge
    task automatic step();
        logic [N-1:0]    exp_rdy;
        logic [PKTW-1:0] pk;
        commit_pkt_t     cp;
        ent_t            e;
        int              g;
        bit              ofire;
        @(negedge clk);
        g = -1;
        if (m_q.size() < 2) begin
            if (m_lock >= 0) begin
                if (in_valid[m_lock]) g = m_lock;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && in_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
                end
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("out_data", out_data, m_q[0].pkt);
            chk("out_unit", out_unit, m_q[0].unit);
        end
        chk("instret_inc", instret_inc, m_inc);
        chk("instret", instret, m_instret);
        if (m_lock >= 0 && (in_ready & ~(N'(1) << m_lock)) != '0) lock_viol++;
        if ((in_ready & in_valid) != '0) obs_acc++;
        ofire = (m_q.size() != 0) && out_ready;
        @(posedge clk);
        m_inc = 0;
        if (ofire) begin
            e  = m_q.pop_front();
            cp = e.pkt;
            if (cp.eop) begin
                m_inc     = $countones(cp.tmask);
                m_instret = m_instret + 64'(m_inc);
            end
        end
        if (g >= 0) begin
            pk = in_data[g*PKTW +: PKTW];
            m_q.push_back('{unit: g, pkt: pk});
            cp = pk;
            if (cp.eop) begin
                m_lock = -1;
                m_rr   = (g + 1) % N;
            end else if (cp.sop) begin
                m_lock = g;
            end
        end
        #1;
        if (g >= 0) begin
            in_valid[g] = 1'b0;
            if (rem[g] > 0) rem[g]--;
        end
    endtask

    task automatic drain();
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (3) step();
    endtask

    task automatic refill_random();
        logic [31:0] r;
        for (int u = 0; u < N; u++) begin
            if (!in_valid[u] && $urandom_range(0, 3) != 0) begin
                if (rem[u] == 0) begin
                    blen[u] = $urandom_range(1, 3);
                    rem[u]  = blen[u];
                end
                r = $urandom();
                put(u, r[3:0], rem[u] == blen[u], rem[u] == 1);
            end
        end
    endtask

    initial begin
        int          acc0;
        int          s1;
        logic [63:0] base;

        for (int u = 0; u < N; u++) begin
            rem[u]  = 0;
            blen[u] = 0;
        end
        model_reset();

        // Reset state, with two units already presenting packets
        put(0, 4'hF, 1'b1, 1'b1);
        put(2, 4'h3, 1'b1, 1'b1);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 4'b0000);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_instret_inc", instret_inc, 3'd0);
        rst = 1'b0;

        // Units 0 and 2 granted in turn, pointer lands on 3
        step();
        chk("t1_first_unit", out_unit, 2'd0);
        step();
        chk("t1_second_unit", out_unit, 2'd2);
        chk("t1_rr_ptr", dut.r_rr_ptr, 2'd3);
        drain();

        // Unit 1 three-packet response while unit 3 keeps asking
        s1 = 0;
        for (int c = 0; c < 10; c++) begin
            if (!in_valid[3]) put(3, 4'h1, 1'b1, 1'b1);
            if (!in_valid[1] && s1 < 3) begin
                put(1, 4'h7, s1 == 0, s1 == 2);
                s1++;
            end
            step();
        end
        chk("t2_lock_hold", lock_viol, 0);
        drain();

        // Writeback stalled: two accepts, then nothing; drains in order
        out_ready = 1'b0;
        acc0 = obs_acc;
        for (int c = 0; c < 5; c++) begin
            for (int u = 0; u < N; u++) if (!in_valid[u]) put(u, 4'h5, 1'b1, 1'b1);
            step();
        end
        chk("t3_accepts", obs_acc - acc0, 2);
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (3) step();

        // Retire counting: tmask 1011 eop, then a sop-only packet
        base = m_instret;
        put(0, 4'b1011, 1'b1, 1'b1);
        step();
        step();
        chk("t4_inc", instret_inc, 3'd3);
        chk("t4_instret", instret, base + 64'd3);
        put(0, 4'b1111, 1'b1, 1'b0);
        step();
        step();
        chk("t4_sop_inc", instret_inc, 3'd0);
        chk("t4_sop_instret", instret, base + 64'd3);
        put(0, 4'b0001, 1'b0, 1'b1);
        step();
        drain();

        // Counter wrap from 2^64-2
        force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.r_instret;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFE;
        put(0, 4'b1111, 1'b1, 1'b1);
        step();
        step();
        chk("t5_wrap", instret, 64'd2);
        drain();

        // Reset while locked with the buffer full
        out_ready = 1'b0;
        put(2, 4'hF, 1'b1, 1'b0);
        step();
        put(2, 4'hF, 1'b0, 1'b0);
        step();
        put(0, 4'h1, 1'b1, 1'b1);
        put(1, 4'h1, 1'b1, 1'b1);
        put(3, 4'h1, 1'b1, 1'b1);
        put(2, 4'hF, 1'b0, 1'b1);
        step();
        rst = 1'b1;
        #1;
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_instret", instret, 64'd0);
        chk("t6_in_ready", in_ready, 4'b0000);
        model_reset();
        for (int u = 0; u < N; u++) put(u, 4'h3, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        chk("t6_first_unit", out_unit, 2'd0);
        repeat (3) step();
        drain();

        // Randomized traffic with random writeback back-pressure
        for (int c = 0; c < 600; c++) begin
            refill_random();
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        chk("lock_hold_all", lock_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
